// File: rtl/flags_update.sv
// flags_update: next-EFLAGS computation for the flags register.
//
// Accepts one flag-affecting operation per handshake and, in the following
// cycle (the "pending" cycle), presents the new EFLAGS image with a write
// strobe. Also tracks the STI interrupt shadow and raises CLI/STI privilege
// faults.
//
// Ports
//   clock            rising-edge clock
//   reset            asynchronous, active-low reset
//   op_valid/ready   operation handshake (ready = !pending, state only)
//   op_code[3:0]     0 ARITH 1 LOGIC 2 INCDEC 3 CLC 4 STC 5 CMC 6 CLD 7 STD
//                    8 CLI 9 STI 10 POPF 11 IRET, 12-15 reserved
//   op_size[1:0]     0 = 8-bit, 1 = 16-bit, 2/3 = 32-bit
//   alu_result/alu_carry/alu_overflow/alu_aux   ALU outputs
//   pop_data[31:0]   popped image for POPF/IRET
//   cpl[1:0]         current privilege level
//   current_eflags   EFLAGS register output
//   instr_retire     one-cycle pulse per retired instruction
//   write_enable     write strobe (pending cycle only)
//   write_data       new EFLAGS image (holds when no write)
//   interrupt_shadow maskable interrupts blocked while high
//   gp_fault         one-cycle pulse in the pending cycle on a privilege fault
//
// Build option
//   FLAGS_UPDATE_IRET_EN  when defined, IRET is a POPF that at cpl 0 also
//                         loads RF and VM; otherwise IRET is a reserved op.
module flags_update (
   input  logic        clock,
   input  logic        reset,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic [3:0]  op_code,
   input  logic [1:0]  op_size,
   input  logic [31:0] alu_result,
   input  logic        alu_carry,
   input  logic        alu_overflow,
   input  logic        alu_aux,
   input  logic [31:0] pop_data,
   input  logic [1:0]  cpl,
   input  logic [31:0] current_eflags,
   input  logic        instr_retire,
   output logic        write_enable,
   output logic [31:0] write_data,
   output logic        interrupt_shadow,
   output logic        gp_fault
);

   localparam logic [3:0] OP_ARITH  = 4'd0;
   localparam logic [3:0] OP_LOGIC  = 4'd1;
   localparam logic [3:0] OP_INCDEC = 4'd2;
   localparam logic [3:0] OP_CLC    = 4'd3;
   localparam logic [3:0] OP_STC    = 4'd4;
   localparam logic [3:0] OP_CMC    = 4'd5;
   localparam logic [3:0] OP_CLD    = 4'd6;
   localparam logic [3:0] OP_STD    = 4'd7;
   localparam logic [3:0] OP_CLI    = 4'd8;
   localparam logic [3:0] OP_STI    = 4'd9;
   localparam logic [3:0] OP_POPF   = 4'd10;
   localparam logic [3:0] OP_IRET   = 4'd11;

   // CF PF AF ZF SF TF DF OF NT: always taken from the popped image
   localparam logic [31:0] POP_ARITH_MASK = 32'h0000_4DD5;
   localparam logic [31:0] IOPL_MASK      = 32'h0000_3000;
   localparam logic [31:0] IF_MASK        = 32'h0000_0200;
   localparam logic [31:0] RF_VM_MASK     = 32'h0003_0000;

   // Even parity of the low result byte (PF semantics).
   function automatic logic parity_even(input logic [7:0] b);
      return ~(^b);
   endfunction

   // Fixed-bit normalisation: bit1 = 1, bits 3, 5, 15, 31:18 = 0.
   function automatic logic [31:0] normalise(input logic [31:0] e);
      logic [31:0] r;
      r        = e;
      r[1]     = 1'b1;
      r[3]     = 1'b0;
      r[5]     = 1'b0;
      r[15]    = 1'b0;
      r[31:18] = '0;
      return r;
   endfunction

   logic        pending_q, we_q, gp_q, shadow_q;
   logic [31:0] wdata_q;
   logic        shadow_d, we_d, gp_d, accept, priv_ok, res_zero, res_sign;
   logic [31:0] n_d, pop_mask;

   assign op_ready         = !pending_q;
   assign accept           = op_valid && !pending_q;
   assign write_enable     = we_q;
   assign write_data       = wdata_q;
   assign gp_fault         = gp_q;
   assign interrupt_shadow = shadow_q;

   assign priv_ok = (cpl <= current_eflags[13:12]);

   always_comb begin
      res_zero = 1'b0;
      res_sign = 1'b0;
      case (op_size)
         2'd0: begin
            res_zero = (alu_result[7:0] == 8'h00);
            res_sign = alu_result[7];
         end
         2'd1: begin
            res_zero = (alu_result[15:0] == 16'h0000);
            res_sign = alu_result[15];
         end
         default: begin
            res_zero = (alu_result == 32'h0000_0000);
            res_sign = alu_result[31];
         end
      endcase
   end

   // Stage 0 -> 1 boundary: next image computed from the accept-cycle EFLAGS
   always_comb begin
      n_d      = normalise(current_eflags);
      we_d     = 1'b0;
      gp_d     = 1'b0;
      pop_mask = POP_ARITH_MASK;
      case (op_code)
         OP_ARITH, OP_LOGIC, OP_INCDEC: begin
            we_d  = 1'b1;
            n_d[2] = parity_even(alu_result[7:0]);
            n_d[6] = res_zero;
            n_d[7] = res_sign;
            if (op_code == OP_LOGIC) begin
               n_d[0]  = 1'b0;
               n_d[4]  = 1'b0;
               n_d[11] = 1'b0;
            end else begin
               n_d[4]  = alu_aux;
               n_d[11] = alu_overflow;
               if (op_code == OP_ARITH) n_d[0] = alu_carry;
            end
         end
         OP_CLC: begin we_d = 1'b1; n_d[0]  = 1'b0; end
         OP_STC: begin we_d = 1'b1; n_d[0]  = 1'b1; end
         OP_CMC: begin we_d = 1'b1; n_d[0]  = ~current_eflags[0]; end
         OP_CLD: begin we_d = 1'b1; n_d[10] = 1'b0; end
         OP_STD: begin we_d = 1'b1; n_d[10] = 1'b1; end
         OP_CLI, OP_STI: begin
            we_d  = priv_ok;
            gp_d  = !priv_ok;
            n_d[9] = (op_code == OP_STI);
         end
`ifdef FLAGS_UPDATE_IRET_EN
         OP_POPF, OP_IRET: begin
`else
         OP_POPF: begin
`endif
            we_d = 1'b1;
            if (cpl == 2'd0) pop_mask = pop_mask | IOPL_MASK;
            if (priv_ok)     pop_mask = pop_mask | IF_MASK;
            n_d = (n_d & ~pop_mask) | (pop_data & pop_mask);
            n_d[16] = 1'b0;
            // Narrow pops leave the whole upper half of EFLAGS alone.
            if (op_size[1] == 1'b0) n_d[31:16] = current_eflags[31:16];
`ifdef FLAGS_UPDATE_IRET_EN
            if (op_code == OP_IRET && cpl == 2'd0)
               n_d = (n_d & ~RF_VM_MASK) | (pop_data & RF_VM_MASK);
`endif
         end
         default: begin
            we_d = 1'b0;
            gp_d = 1'b0;
         end
      endcase
   end

   // Shadow: retire clears first, then an accepted STI/CLI overrides it.
   always_comb begin
      shadow_d = shadow_q;
      if (shadow_q && instr_retire) shadow_d = 1'b0;
      if (accept && priv_ok && op_code == OP_STI && !current_eflags[9])
         shadow_d = 1'b1;
      if (accept && priv_ok && op_code == OP_CLI)
         shadow_d = 1'b0;
   end

   // Stage 1: one-entry output register (the pending cycle)
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pending_q <= 1'b0;
         we_q      <= 1'b0;
         gp_q      <= 1'b0;
         shadow_q  <= 1'b0;
         wdata_q   <= 32'h0000_0000;
      end else begin
         pending_q <= accept;
         we_q      <= accept && we_d;
         gp_q      <= accept && gp_d;
         shadow_q  <= shadow_d;
         if (accept && we_d) wdata_q <= n_d;
      end
   end

endmodule

// File: tb/tb_flags_update.sv
module tb_flags_update;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        op_valid = 1'b0;
   logic        op_ready;
   logic [3:0]  op_code = '0;
   logic [1:0]  op_size = '0;
   logic [31:0] alu_result = '0;
   logic        alu_carry = 1'b0;
   logic        alu_overflow = 1'b0;
   logic        alu_aux = 1'b0;
   logic [31:0] pop_data = '0;
   logic [1:0]  cpl = '0;
   logic [31:0] current_eflags = '0;
   logic        instr_retire = 1'b0;
   logic        write_enable;
   logic [31:0] write_data;
   logic        interrupt_shadow;
   logic        gp_fault;

   flags_update dut (
      .clock(clock), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
      .op_code(op_code), .op_size(op_size), .alu_result(alu_result),
      .alu_carry(alu_carry), .alu_overflow(alu_overflow), .alu_aux(alu_aux),
      .pop_data(pop_data), .cpl(cpl), .current_eflags(current_eflags),
      .instr_retire(instr_retire), .write_enable(write_enable),
      .write_data(write_data), .interrupt_shadow(interrupt_shadow),
      .gp_fault(gp_fault)
   );

   always #5 clock = ~clock;

   typedef struct {
      string       name;
      logic        we;
      logic [31:0] wd;
      logic        gp;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_wd = 32'h0;
   bit          mon_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Monitor: pops one expectation in every pending cycle, otherwise the
   // strobe and the fault must be quiet.
   always @(negedge clock) begin
      if (mon_en) begin
         if (!op_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_pending", 32'(op_ready), 32'd1);
            end else begin
               exp_t x;
               x = exp_q.pop_front();
               check({x.name, "_we"}, 32'(write_enable), 32'(x.we));
               check({x.name, "_wd"}, write_data, x.wd);
               check({x.name, "_gp"}, 32'(gp_fault), 32'(x.gp));
            end
         end else begin
            check("idle_quiet", {30'h0, write_enable, gp_fault}, 32'h0);
         end
      end
   end

   // Drives one op, pushes its expectation, returns inside the pending cycle.
   task automatic do_op(input string name, input logic [3:0] op, input logic [1:0] sz,
                        input logic [31:0] res, input logic [2:0] coa,
                        input logic [31:0] pop, input logic [1:0] pl,
                        input logic [31:0] e, input logic xwe, input logic [31:0] xd,
                        input logic xgp, input bit push);
      exp_t x;
      int   n;
      n = 0;
      op_code = op; op_size = sz; alu_result = res;
      {alu_carry, alu_overflow, alu_aux} = coa;
      pop_data = pop; cpl = pl; current_eflags = e;
      op_valid = 1'b1;
      while (!op_ready && n < 8) begin
         @(posedge clock); #1;
         n++;
      end
      if (!op_ready) check({name, "_ready_timeout"}, 32'(op_ready), 32'd1);
      if (push) begin
         x.name = name; x.we = xwe; x.gp = xgp;
         x.wd = xwe ? xd : last_wd;
         if (xwe) last_wd = xd;
         exp_q.push_back(x);
      end
      @(posedge clock); #1;
      op_valid = 1'b0;
   endtask

   task automatic op(input string name, input logic [3:0] opc, input logic [1:0] sz,
                     input logic [31:0] res, input logic [2:0] coa,
                     input logic [31:0] pop, input logic [1:0] pl,
                     input logic [31:0] e, input logic xwe, input logic [31:0] xd,
                     input logic xgp);
      do_op(name, opc, sz, res, coa, pop, pl, e, xwe, xd, xgp, 1'b1);
      @(posedge clock); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time %0t exceeded limit 200000", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      check("rst_ready",  32'(op_ready), 32'd1);
      check("rst_we",     32'(write_enable), 32'd0);
      check("rst_wd",     write_data, 32'h0);
      check("rst_shadow", 32'(interrupt_shadow), 32'd0);
      check("rst_gp",     32'(gp_fault), 32'd0);
      @(posedge clock); #1;
      reset = 1'b1;
      mon_en = 1'b1;
      @(posedge clock); #1;

      // ALU ops: coa = {carry, overflow, aux}
      op("arith_b_zero", 4'd0, 2'd0, 32'h0000_0100, 3'b100, 32'h0, 2'd0, 32'h0000_0002, 1'b1, 32'h0000_0047, 1'b0);
      do_op("logic_d", 4'd1, 2'd2, 32'h8000_0003, 3'b111, 32'h0, 2'd0, 32'h0000_0002, 1'b1, 32'h0000_0086, 1'b0, 1'b1);
      check("logic_ready_pending", 32'(op_ready), 32'd0);
      @(posedge clock); #1;
      check("logic_ready_after", 32'(op_ready), 32'd1);
      op("incdec_w",     4'd2, 2'd1, 32'h0000_FFFF, 3'b001, 32'h0, 2'd0, 32'h0000_0003, 1'b1, 32'h0000_0097, 1'b0);
      op("arith_b_of",   4'd0, 2'd0, 32'h0000_0180, 3'b010, 32'h0, 2'd0, 32'h0000_0002, 1'b1, 32'h0000_0882, 1'b0);

      // Carry / direction flags, fixed-bit normalisation
      op("cmc", 4'd5, 2'd2, 32'h0, 3'b000, 32'h0, 2'd0, 32'h0000_0003, 1'b1, 32'h0000_0002, 1'b0);
      op("stc", 4'd4, 2'd2, 32'h0, 3'b000, 32'h0, 2'd0, 32'h0000_0002, 1'b1, 32'h0000_0003, 1'b0);
      op("cld", 4'd6, 2'd2, 32'h0, 3'b000, 32'h0, 2'd0, 32'h0000_0402, 1'b1, 32'h0000_0002, 1'b0);
      op("std", 4'd7, 2'd2, 32'h0, 3'b000, 32'h0, 2'd0, 32'h0000_0002, 1'b1, 32'h0000_0402, 1'b0);
      op("clc_norm", 4'd3, 2'd2, 32'h0, 3'b000, 32'h0, 2'd0, 32'hFFFF_FFFF, 1'b1, 32'h0003_7FD6, 1'b0);

      // Privilege: faulting STI, permitted CLI
      op("sti_fault", 4'd9, 2'd2, 32'h0, 3'b000, 32'h0, 2'd3, 32'h0000_0002, 1'b0, 32'h0, 1'b1);
      check("sti_fault_shadow", 32'(interrupt_shadow), 32'd0);
      op("cli_ok", 4'd8, 2'd2, 32'h0, 3'b000, 32'h0, 2'd1, 32'h0000_1202, 1'b1, 32'h0000_1002, 1'b0);

      // Interrupt shadow
      do_op("sti_set", 4'd9, 2'd2, 32'h0, 3'b000, 32'h0, 2'd0, 32'h0000_0002, 1'b1, 32'h0000_0202, 1'b0, 1'b1);
      check("shadow_set", 32'(interrupt_shadow), 32'd1);
      @(posedge clock); #1;
      instr_retire = 1'b1;
      @(posedge clock); #1;
      instr_retire = 1'b0;
      check("shadow_retire_clear", 32'(interrupt_shadow), 32'd0);
      op("sti_if1", 4'd9, 2'd2, 32'h0, 3'b000, 32'h0, 2'd0, 32'h0000_0202, 1'b1, 32'h0000_0202, 1'b0);
      check("shadow_if1_stays0", 32'(interrupt_shadow), 32'd0);
      op("sti_set2", 4'd9, 2'd2, 32'h0, 3'b000, 32'h0, 2'd0, 32'h0000_0002, 1'b1, 32'h0000_0202, 1'b0);
      instr_retire = 1'b1;
      do_op("sti_vs_retire", 4'd9, 2'd2, 32'h0, 3'b000, 32'h0, 2'd0, 32'h0000_0002, 1'b1, 32'h0000_0202, 1'b0, 1'b1);
      instr_retire = 1'b0;
      check("shadow_set_wins", 32'(interrupt_shadow), 32'd1);
      @(posedge clock); #1;
      op("cli_clear", 4'd8, 2'd2, 32'h0, 3'b000, 32'h0, 2'd0, 32'h0000_0202, 1'b1, 32'h0000_0002, 1'b0);
      check("shadow_cli_clear", 32'(interrupt_shadow), 32'd0);

      // POPF
      op("popf_user", 4'd10, 2'd2, 32'h0, 3'b000, 32'hFFFF_FFFF, 2'd3, 32'h0002_0002, 1'b1, 32'h0002_4DD7, 1'b0);
      op("popf_kern", 4'd10, 2'd2, 32'h0, 3'b000, 32'h0000_3000, 2'd0, 32'h0000_0002, 1'b1, 32'h0000_3002, 1'b0);

      // IRET
`ifdef FLAGS_UPDATE_IRET_EN
      op("iret", 4'd11, 2'd2, 32'h0, 3'b000, 32'h0003_0202, 2'd0, 32'h0000_0002, 1'b1, 32'h0003_0202, 1'b0);
`else
      op("iret", 4'd11, 2'd2, 32'h0, 3'b000, 32'h0003_0202, 2'd0, 32'h0000_0002, 1'b0, 32'h0, 1'b0);
`endif

      // Reserved op
      op("reserved", 4'd13, 2'd2, 32'h0, 3'b000, 32'hFFFF_FFFF, 2'd3, 32'h0000_0002, 1'b0, 32'h0, 1'b0);

      // Reset during the pending cycle drops the write
      do_op("rst_pending", 4'd0, 2'd2, 32'h0000_0001, 3'b000, 32'h0, 2'd0, 32'h0000_0002, 1'b1, 32'h0, 1'b0, 1'b0);
      reset = 1'b0;
      #1;
      check("rst_pending_we", 32'(write_enable), 32'd0);
      check("rst_pending_ready", 32'(op_ready), 32'd1);
      @(posedge clock); #1;
      check("rst_pending_we_edge", 32'(write_enable), 32'd0);
      reset = 1'b1;
      last_wd = 32'h0;
      check("rst_pending_wd", write_data, 32'h0);
      @(posedge clock); #1;
      check("rst_pending_we_after", 32'(write_enable), 32'd0);

      @(posedge clock); #1;
      @(posedge clock); #1;
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
